// File: rtl/rob_ctrl_pkg.sv
// Shared constants, entry type and decode helpers for the reorder-buffer controller.
package rob_ctrl_pkg;

  localparam int ISSUE_WIDTH_MAX = 2;
  localparam int ROB_MAX_RETIRE  = 2;
  localparam int ROB_SIZE        = 32;
  localparam int ROB_SIZE_CLOG   = 5;
  localparam int SRC_LEN         = 5;
  localparam int OPCODE_LEN      = 7;
  localparam int NUM_CDB         = 2;

  localparam int ALLOC_CNT_W = $clog2(ISSUE_WIDTH_MAX + 1);
  localparam int RET_CNT_W   = $clog2(ROB_MAX_RETIRE + 1);
  localparam int RET_LANE_W  = (ROB_MAX_RETIRE > 1) ? $clog2(ROB_MAX_RETIRE) : 1;

  localparam logic [OPCODE_LEN-1:0] S_TYPE  = 7'b0100011;
  localparam logic [OPCODE_LEN-1:0] SB_TYPE = 7'b1100011;

  typedef logic [ROB_SIZE_CLOG-1:0] rob_id_t;
  typedef logic [ROB_SIZE_CLOG:0]   rob_cnt_t;
  typedef logic [SRC_LEN-1:0]       reg_idx_t;
  typedef logic [OPCODE_LEN-1:0]    opcode_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     mispred;
    logic     no_rd;
    reg_idx_t rd;
  } rob_ety_t;

  typedef rob_ety_t [ROB_SIZE-1:0] rob_arr_t;

  // Stores, branches and writes to x0 leave the register file untouched at retire.
  function automatic logic writes_no_rd(opcode_t op, reg_idx_t rd);
    return (op == S_TYPE) || (op == SB_TYPE) || (rd == '0);
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Issue, writeback and retire signals between the FRAT side and the ROB controller.
interface rob_ctrl_if;
  import rob_ctrl_pkg::*;

  logic    [ISSUE_WIDTH_MAX-1:0] instr_val_id;
  opcode_t [ISSUE_WIDTH_MAX-1:0] opcode_id;
  reg_idx_t [ISSUE_WIDTH_MAX-1:0] rd_id;
  rob_id_t                       rob_is_ptr;
  rob_id_t                       rob_is_ptr_p1;
  logic                          rob_full;

  logic    [NUM_CDB-1:0]         cdb_val;
  rob_id_t [NUM_CDB-1:0]         cdb_robid;
  logic    [NUM_CDB-1:0]         cdb_mispredict;

  reg_idx_t [ROB_MAX_RETIRE-1:0] rd_ret;
  logic    [ROB_MAX_RETIRE-1:0]  val_ret;
  logic    [ROB_MAX_RETIRE-1:0]  branch_ret;
  rob_id_t [ROB_MAX_RETIRE-1:0]  robid_ret;
  logic                          branch_clear_id;
  rob_id_t                       mispredict_tag_id;

  modport master (
    output instr_val_id, opcode_id, rd_id, cdb_val, cdb_robid, cdb_mispredict,
    input  rob_is_ptr, rob_is_ptr_p1, rob_full, rd_ret, val_ret, branch_ret,
           robid_ret, branch_clear_id, mispredict_tag_id
  );

  modport slave (
    input  instr_val_id, opcode_id, rd_id, cdb_val, cdb_robid, cdb_mispredict,
    output rob_is_ptr, rob_is_ptr_p1, rob_full, rd_ret, val_ret, branch_ret,
           robid_ret, branch_clear_id, mispredict_tag_id
  );

endinterface

// File: rtl/rob_retire_sel.sv
// In-order retire window selection starting at head; stops at the first
// not-yet-complete entry or right after a mispredicted one.
module rob_retire_sel
  import rob_ctrl_pkg::*;
(
  input  rob_id_t                   head,
  input  rob_arr_t                  entries,
  output logic [ROB_MAX_RETIRE-1:0] ret_en,
  output logic [RET_CNT_W-1:0]      ret_cnt,
  output logic                      mis_hit,
  output logic [RET_LANE_W-1:0]     mis_lane
);

  logic    scan_go;
  rob_id_t idx;

  always_comb begin
    ret_en   = '0;
    ret_cnt  = '0;
    mis_hit  = 1'b0;
    mis_lane = '0;
    scan_go  = 1'b1;
    idx      = head;
    for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
      idx = head + rob_id_t'(j);
      if (scan_go && entries[idx].valid && entries[idx].done) begin
        ret_en[j] = 1'b1;
        ret_cnt   = ret_cnt + RET_CNT_W'(1);
        if (entries[idx].mispred) begin
          mis_hit  = 1'b1;
          mis_lane = RET_LANE_W'(j);
          scan_go  = 1'b0;
        end
      end else begin
        scan_go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: allocates IDs at issue, marks completion from the
// CDBs, retires in program order and flushes on a mispredicted branch.
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  rob_ctrl_if.slave rob
);

  localparam rob_cnt_t ROB_SIZE_C = rob_cnt_t'(ROB_SIZE);
  localparam rob_cnt_t ISSUE_W_C  = rob_cnt_t'(ISSUE_WIDTH_MAX);

  rob_arr_t rob_q;
  rob_id_t  head_q;
  rob_id_t  tail_q;
  rob_cnt_t count_q;
  logic     flush_pending_q;

  logic                          rob_full_c;
  logic [ALLOC_CNT_W-1:0]        alloc_cnt;
  logic [ALLOC_CNT_W-1:0]        alloc_eff;
  rob_id_t [ISSUE_WIDTH_MAX-1:0] alloc_id;
  rob_id_t [ROB_MAX_RETIRE-1:0]  ret_id;
  rob_id_t                       mis_id;

  logic [ROB_MAX_RETIRE-1:0] ret_en;
  logic [RET_CNT_W-1:0]      ret_cnt;
  logic                      mis_hit;
  logic [RET_LANE_W-1:0]     mis_lane;

  rob_retire_sel u_retire_sel (
    .head     (head_q),
    .entries  (rob_q),
    .ret_en   (ret_en),
    .ret_cnt  (ret_cnt),
    .mis_hit  (mis_hit),
    .mis_lane (mis_lane)
  );

  // Valid issue lanes are packed onto consecutive IDs starting at tail.
  always_comb begin
    rob_full_c = ((ROB_SIZE_C - count_q) < ISSUE_W_C) | flush_pending_q;
    alloc_cnt  = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      alloc_id[i] = tail_q + rob_id_t'(alloc_cnt);
      alloc_cnt   = alloc_cnt + ALLOC_CNT_W'(rob.instr_val_id[i]);
    end
    alloc_eff = rob_full_c ? '0 : alloc_cnt;
    for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
      ret_id[j] = head_q + rob_id_t'(j);
    end
    mis_id = head_q + rob_id_t'(mis_lane);
  end

  assign rob.rob_full      = rob_full_c;
  assign rob.rob_is_ptr    = tail_q;
  assign rob.rob_is_ptr_p1 = tail_q + rob_id_t'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        rob_q[i] <= '0;
      end
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      flush_pending_q       <= 1'b0;
      rob.val_ret           <= '0;
      rob.branch_ret        <= '0;
      rob.rd_ret            <= '0;
      rob.robid_ret         <= '0;
      rob.branch_clear_id   <= 1'b0;
      rob.mispredict_tag_id <= '0;
    end else begin
      for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
        rob.val_ret[j]    <= ret_en[j];
        rob.branch_ret[j] <= ret_en[j] & rob_q[ret_id[j]].no_rd;
        rob.rd_ret[j]     <= ret_en[j] ? rob_q[ret_id[j]].rd : '0;
        rob.robid_ret[j]  <= ret_en[j] ? ret_id[j] : '0;
      end
      rob.branch_clear_id <= mis_hit;
      flush_pending_q     <= mis_hit;
      if (mis_hit) begin
        rob.mispredict_tag_id <= mis_id;
      end

      // A retiring mispredict wipes the window and overrides this cycle's allocation.
      if (mis_hit) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob_q[i].valid <= 1'b0;
        end
        head_q  <= mis_id + rob_id_t'(1);
        tail_q  <= mis_id + rob_id_t'(1);
        count_q <= '0;
      end else begin
        for (int k = 0; k < NUM_CDB; k++) begin
          if (rob.cdb_val[k] && rob_q[rob.cdb_robid[k]].valid) begin
            rob_q[rob.cdb_robid[k]].done <= 1'b1;
            if (rob.cdb_mispredict[k]) begin
              rob_q[rob.cdb_robid[k]].mispred <= 1'b1;
            end
          end
        end
        for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
          if (ret_en[j]) begin
            rob_q[ret_id[j]].valid <= 1'b0;
          end
        end
        if (!rob_full_c) begin
          for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            if (rob.instr_val_id[i]) begin
              rob_q[alloc_id[i]] <= '{valid:   1'b1,
                                      done:    1'b0,
                                      mispred: 1'b0,
                                      no_rd:   writes_no_rd(rob.opcode_id[i], rob.rd_id[i]),
                                      rd:      rob.rd_id[i]};
            end
          end
        end
        head_q  <= head_q + rob_id_t'(ret_cnt);
        tail_q  <= tail_q + rob_id_t'(alloc_eff);
        count_q <= count_q + rob_cnt_t'(alloc_eff) - rob_cnt_t'(ret_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl: allocation, completion, in-order
// retire, full/wrap boundary, mispredict flush and mid-operation reset.
module tb_rob_ctrl;
  import rob_ctrl_pkg::*;

  localparam opcode_t ALU = 7'b0110011;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rob_ctrl_if rif ();

  rob_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rob (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] val, input opcode_t op0, input reg_idx_t rd0,
                               input opcode_t op1, input reg_idx_t rd1);
    rif.instr_val_id = val;
    rif.opcode_id[0] = op0;
    rif.rd_id[0]     = rd0;
    rif.opcode_id[1] = op1;
    rif.rd_id[1]     = rd1;
  endtask

  task automatic applyCdb(input logic [1:0] val, input rob_id_t id0, input rob_id_t id1,
                          input logic [1:0] mis);
    rif.cdb_val        = val;
    rif.cdb_robid[0]   = id0;
    rif.cdb_robid[1]   = id1;
    rif.cdb_mispredict = mis;
  endtask

  task automatic idle();
    applyStimulus(2'b00, ALU, 5'd0, ALU, 5'd0);
    applyCdb(2'b00, 5'd0, 5'd0, 2'b00);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_is_ptr", 32'(rif.rob_is_ptr), 0);
    checkOutput("rst_is_ptr_p1", 32'(rif.rob_is_ptr_p1), 1);
    checkOutput("rst_full", 32'(rif.rob_full), 0);
    checkOutput("rst_val_ret", 32'(rif.val_ret), 0);
    checkOutput("rst_clear", 32'(rif.branch_clear_id), 0);

    $display("[TB] dual allocation and in-order retire");
    applyStimulus(2'b11, ALU, 5'd3, ALU, 5'd4);
    checkOutput("alloc_ptr", 32'(rif.rob_is_ptr), 0);
    checkOutput("alloc_ptr_p1", 32'(rif.rob_is_ptr_p1), 1);
    step();
    idle();
    checkOutput("alloc_ptr_next", 32'(rif.rob_is_ptr), 2);
    checkOutput("alloc_count", 32'(dut.count_q), 2);
    applyCdb(2'b01, 5'd1, 5'd0, 2'b00);
    step();
    idle();
    step();
    checkOutput("wait_head_val_ret", 32'(rif.val_ret), 0);
    applyCdb(2'b01, 5'd0, 5'd0, 2'b00);
    step();
    idle();
    checkOutput("head_done_val_ret", 32'(rif.val_ret), 0);
    step();
    checkOutput("ret_val", 32'(rif.val_ret), 3);
    checkOutput("ret_robid", 32'(rif.robid_ret), 32'((1 << 5) | 0));
    checkOutput("ret_rd", 32'(rif.rd_ret), 32'((4 << 5) | 3));
    checkOutput("ret_branch", 32'(rif.branch_ret), 0);
    checkOutput("ret_count", 32'(dut.count_q), 0);

    $display("[TB] full boundary and tail wrap");
    doReset();
    for (int i = 0; i < 31; i++) begin
      applyStimulus(2'b01, ALU, reg_idx_t'(i + 1), ALU, 5'd0);
      step();
    end
    idle();
    checkOutput("full_at_31", 32'(rif.rob_full), 1);
    checkOutput("full_ptr", 32'(rif.rob_is_ptr), 31);
    checkOutput("full_count", 32'(dut.count_q), 31);
    applyStimulus(2'b01, ALU, 5'd7, ALU, 5'd0);
    step();
    idle();
    checkOutput("full_ignored_count", 32'(dut.count_q), 31);
    checkOutput("full_ignored_ptr", 32'(rif.rob_is_ptr), 31);
    applyCdb(2'b11, 5'd0, 5'd1, 2'b00);
    step();
    idle();
    step();
    checkOutput("drain_val_ret", 32'(rif.val_ret), 3);
    checkOutput("drain_count", 32'(dut.count_q), 29);
    checkOutput("drain_full", 32'(rif.rob_full), 0);
    applyStimulus(2'b11, ALU, 5'd20, ALU, 5'd21);
    checkOutput("wrap_ptr", 32'(rif.rob_is_ptr), 31);
    checkOutput("wrap_ptr_p1", 32'(rif.rob_is_ptr_p1), 0);
    step();
    idle();
    checkOutput("wrap_ptr_next", 32'(rif.rob_is_ptr), 1);
    checkOutput("wrap_full", 32'(rif.rob_full), 1);

    $display("[TB] mispredicted branch flush");
    doReset();
    applyStimulus(2'b11, ALU, 5'd1, ALU, 5'd2);     step();
    applyStimulus(2'b11, ALU, 5'd3, ALU, 5'd4);     step();
    applyStimulus(2'b11, ALU, 5'd5, SB_TYPE, 5'd7); step();
    applyStimulus(2'b11, ALU, 5'd6, ALU, 5'd8);     step();
    applyStimulus(2'b11, ALU, 5'd9, ALU, 5'd10);    step();
    idle();
    checkOutput("br_count", 32'(dut.count_q), 10);
    applyCdb(2'b11, 5'd0, 5'd1, 2'b00); step();
    applyCdb(2'b11, 5'd2, 5'd3, 2'b00); step();
    checkOutput("br_ret01", 32'(rif.robid_ret), 32'((1 << 5) | 0));
    applyCdb(2'b11, 5'd4, 5'd6, 2'b00); step();
    applyCdb(2'b11, 5'd7, 5'd8, 2'b00); step();
    checkOutput("br_ret4_val", 32'(rif.val_ret), 1);
    checkOutput("br_ret4_id", 32'(rif.robid_ret), 4);
    applyCdb(2'b11, 5'd9, 5'd5, 2'b10); step();
    idle();
    checkOutput("br_wait_val_ret", 32'(rif.val_ret), 0);
    step();
    checkOutput("br_val_ret", 32'(rif.val_ret), 1);
    checkOutput("br_branch_ret", 32'(rif.branch_ret), 1);
    checkOutput("br_robid", 32'(rif.robid_ret), 5);
    checkOutput("br_rd", 32'(rif.rd_ret), 7);
    checkOutput("br_clear", 32'(rif.branch_clear_id), 1);
    checkOutput("br_tag", 32'(rif.mispredict_tag_id), 5);
    checkOutput("br_count_zero", 32'(dut.count_q), 0);
    checkOutput("br_head", 32'(dut.head_q), 6);
    checkOutput("br_tail", 32'(rif.rob_is_ptr), 6);
    checkOutput("br_full_pending", 32'(rif.rob_full), 1);
    applyStimulus(2'b01, ALU, 5'd11, ALU, 5'd0);
    step();
    idle();
    checkOutput("br_clear_drop", 32'(rif.branch_clear_id), 0);
    checkOutput("br_alloc_blocked", 32'(rif.rob_is_ptr), 6);
    checkOutput("br_full_release", 32'(rif.rob_full), 0);
    checkOutput("br_val_ret_idle", 32'(rif.val_ret), 0);

    $display("[TB] store and x0 writer retire without rd");
    applyStimulus(2'b11, S_TYPE, 5'd9, ALU, 5'd0);
    step();
    idle();
    applyCdb(2'b11, 5'd6, 5'd7, 2'b00);
    step();
    idle();
    step();
    checkOutput("nord_val_ret", 32'(rif.val_ret), 3);
    checkOutput("nord_branch_ret", 32'(rif.branch_ret), 3);
    checkOutput("nord_robid", 32'(rif.robid_ret), 32'((7 << 5) | 6));
    checkOutput("nord_rd", 32'(rif.rd_ret), 32'((0 << 5) | 9));

    $display("[TB] lane1-only allocation");
    applyStimulus(2'b10, ALU, 5'd0, ALU, 5'd12);
    checkOutput("lane1_ptr", 32'(rif.rob_is_ptr), 8);
    step();
    idle();
    checkOutput("lane1_ptr_next", 32'(rif.rob_is_ptr), 9);
    applyCdb(2'b01, 5'd8, 5'd0, 2'b00);
    step();
    idle();
    step();
    checkOutput("lane1_val_ret", 32'(rif.val_ret), 1);
    checkOutput("lane1_robid", 32'(rif.robid_ret), 8);
    checkOutput("lane1_rd", 32'(rif.rd_ret), 12);
    checkOutput("lane1_branch_ret", 32'(rif.branch_ret), 0);

    $display("[TB] reset with entries in flight and a flush about to fire");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, ALU, reg_idx_t'(2 * i + 1), ALU, reg_idx_t'(2 * i + 2));
      step();
    end
    idle();
    checkOutput("inflight_count", 32'(dut.count_q), 10);
    applyCdb(2'b01, 5'd9, 5'd0, 2'b01);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_val_ret", 32'(rif.val_ret), 0);
    checkOutput("mid_rst_branch_ret", 32'(rif.branch_ret), 0);
    checkOutput("mid_rst_rd", 32'(rif.rd_ret), 0);
    checkOutput("mid_rst_robid", 32'(rif.robid_ret), 0);
    checkOutput("mid_rst_clear", 32'(rif.branch_clear_id), 0);
    checkOutput("mid_rst_tag", 32'(rif.mispredict_tag_id), 0);
    checkOutput("mid_rst_full", 32'(rif.rob_full), 0);
    checkOutput("mid_rst_count", 32'(dut.count_q), 0);
    applyStimulus(2'b01, ALU, 5'd3, ALU, 5'd0);
    checkOutput("post_rst_ptr", 32'(rif.rob_is_ptr), 0);
    step();
    idle();
    checkOutput("post_rst_ptr_next", 32'(rif.rob_is_ptr), 1);
    checkOutput("post_rst_no_clear", 32'(rif.branch_clear_id), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
